// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ula execute sequencer.
//   - ALU opcode encodings (110/111 are illegal)
//   - sequencer FSM state encoding
//   - bit positions of the fields inside the 16-bit instruction word
package ula_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Instruction layout: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm
  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;

  // Opcodes 110 and 111 have no ALU operation and retire as illegal.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// ula_regfile: NREG x DATA_W register file, asynchronously cleared to 0.
//   clk, reset          clock, asynchronous active-high reset
//   we, waddr, wdata    synchronous write port
//   raddr1 -> rdata1    combinational read port (rs1)
//   raddr2 -> rdata2    combinational read port (rs2)
//   dbg_addr -> dbg_data combinational debug read port
module ula_regfile
  import ula_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: multi-cycle execute sequencer for the 16-bit signed ALU (ula).
// Accepts one instruction via instr_valid/instr_ready, reads operands from the
// internal register file, drives the external ALU, captures its result and
// writes it back. One instruction in flight: IDLE -> READ -> EXEC -> WB.
//   clk, reset                 clock, asynchronous active-high reset
//   instr_valid/ready, instr   instruction handshake (ready only in IDLE)
//   alu_opcode, alu_a, alu_b   registered ALU operands (set in READ)
//   alu_result                 combinational ALU result (captured in EXEC)
//   done, done_rd, done_data   retirement pulse with destination and value
//   illegal                    pulses with done for opcodes 110/111
//   ovf                        signed overflow, valid with done
//   dbg_addr -> dbg_data       combinational register-file debug read
// Optional feature: define ULA_CTRL_OVF_EN to build the overflow detector;
// otherwise ovf is tied to 0.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IMM_W  = 7,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [RA_W-1:0]   done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              illegal,
  output logic              ovf,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t state, state_nx;

  logic [INSTR_W-1:0] ir;
  logic [2:0]         ir_op;
  logic [RA_W-1:0]    ir_rd, ir_rs1, ir_rs2;
  logic [IMM_W-1:0]   ir_imm;
  logic [DATA_W-1:0]  rs1_data, rs2_data, res_q;
  logic               hs, wen, ill_op;

  assign ir_op  = ir[OP_LSB +: 3];
  assign ir_rd  = ir[RD_LSB +: RA_W];
  assign ir_rs1 = ir[RS1_LSB +: RA_W];
  assign ir_rs2 = ir[RS2_LSB +: RA_W];
  assign ir_imm = ir[IMM_LSB +: IMM_W];
  assign ill_op = is_illegal_op(ir_op);
  assign hs     = instr_valid & instr_ready;

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: every state except IDLE lasts exactly one cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs) state_nx = READ;
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    instr_ready = (state == IDLE);
    done        = (state == WB);
    illegal     = (state == WB) && ill_op;
    wen         = (state == WB) && !ill_op;
  end

  // Instruction latch, operand selection and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir         <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_q      <= '0;
    end else begin
      if (hs) ir <= instr;
      if (state == READ) begin
        alu_opcode <= ir_op;
        alu_a      <= (ir_op == OP_LOAD) ? '0 : rs1_data;
        unique case (ir_op)
          OP_LOAD, OP_ADDI, OP_SUBI: alu_b <= sext(ir_imm);
          OP_ADD, OP_SUB, OP_MUL:    alu_b <= rs2_data;
          default:                   alu_b <= '0;
        endcase
      end
      if (state == EXEC) res_q <= alu_result;
    end
  end

  assign done_rd   = ir_rd;
  assign done_data = res_q;

`ifdef ULA_CTRL_OVF_EN
  logic ovf_q;

  function automatic logic add_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Full product overflows when its upper half is not the sign extension of the low half
  function automatic logic mul_ovf(input logic [DATA_W-1:0] a, b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    return p != {{DATA_W{p[DATA_W-1]}}, p[DATA_W-1:0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state == EXEC) begin
      unique case (alu_opcode)
        OP_ADD, OP_ADDI: ovf_q <= add_ovf(alu_a, alu_b, alu_result);
        OP_SUB, OP_SUBI: ovf_q <= sub_ovf(alu_a, alu_b, alu_result);
        OP_MUL:          ovf_q <= mul_ovf(alu_a, alu_b);
        default:         ovf_q <= 1'b0;
      endcase
    end
  end

  assign ovf = done & ovf_q;
`else
  assign ovf = 1'b0;
`endif

  ula_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (wen),
    .waddr    (ir_rd),
    .wdata    (res_q),
    .raddr1   (ir_rs1),
    .rdata1   (rs1_data),
    .raddr2   (ir_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: directed, table-driven bench for ula_ctrl with a behavioural
// model of the ula ALU. Expected overflow follows ULA_CTRL_OVF_EN.
module tb_ula_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        done;
  logic [2:0]  done_rd;
  logic [15:0] done_data;
  logic        illegal;
  logic        ovf;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  ula_ctrl #(.DATA_W(16), .NREG(8), .IMM_W(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .done        (done),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal),
    .ovf         (ovf),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ula
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b000, 3'b001, 3'b010: alu_result = alu_a + alu_b;
      3'b011, 3'b100:         alu_result = alu_a - alu_b;
      3'b101:                 alu_result = alu_a * alu_b;
      default:                alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  rd;
    logic [15:0] data;  // expected R[rd] after retirement
    logic        ill;
    logic        ovf;   // overflow with the detector built in
  } vec_t;

  vec_t        vt[18];
  logic [15:0] mreg[8];

  function automatic logic [15:0] enc_i(input logic [2:0] op, rd, rs1, input logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] op, rd, rs1, rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic d1, d2, d3, r1, r2, r3;
    logic exp_ovf;
`ifdef ULA_CTRL_OVF_EN
    exp_ovf = v.ovf;
`else
    exp_ovf = 1'b0;
`endif
    issue(v.ins);
    d1 = done; r1 = instr_ready;          // READ
    step();
    d2 = done; r2 = instr_ready;          // EXEC
    step();
    dbg_addr = v.rd;
    #1;
    d3 = done; r3 = instr_ready;          // WB
    chk($sformatf("v%0d latency", idx), {29'd0, d1, d2, d3}, 32'b001);
    chk($sformatf("v%0d ready_busy", idx), {29'd0, r1, r2, r3}, 32'd0);
    chk($sformatf("v%0d done_rd", idx), {29'd0, done_rd}, {29'd0, v.rd});
    chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
    chk($sformatf("v%0d ovf", idx), {31'd0, ovf}, {31'd0, exp_ovf});
    if (!v.ill) chk($sformatf("v%0d done_data", idx), {16'd0, done_data}, {16'd0, v.data});
    chk($sformatf("v%0d dbg_old", idx), {16'd0, dbg_data}, {16'd0, mreg[v.rd]});
    step();
    if (!v.ill) mreg[v.rd] = v.data;
    chk($sformatf("v%0d reg_after", idx), {16'd0, dbg_data}, {16'd0, mreg[v.rd]});
    chk($sformatf("v%0d idle", idx), {30'd0, instr_ready, done}, 32'b10);
  endtask

  logic [14:0] done_mask, ready_mask;

  initial begin
    vt[0]  = '{enc_i(3'b000, 3'd1, 3'd0, 7'd5),    3'd1, 16'h0005, 1'b0, 1'b0}; // LOAD R1,#5
    vt[1]  = '{enc_i(3'b010, 3'd2, 3'd1, 7'h7D),   3'd2, 16'h0002, 1'b0, 1'b0}; // ADDI R2,R1,#-3
    vt[2]  = '{enc_i(3'b000, 3'd1, 3'd2, 7'd7),    3'd1, 16'h0007, 1'b0, 1'b0}; // LOAD R1,#7 (rs1 ignored)
    vt[3]  = '{enc_i(3'b000, 3'd2, 3'd0, 7'h7C),   3'd2, 16'hFFFC, 1'b0, 1'b0}; // LOAD R2,#-4
    vt[4]  = '{enc_r(3'b001, 3'd3, 3'd1, 3'd2),    3'd3, 16'h0003, 1'b0, 1'b0}; // ADD R3,R1,R2
    vt[5]  = '{enc_r(3'b011, 3'd4, 3'd1, 3'd2),    3'd4, 16'h000B, 1'b0, 1'b0}; // SUB R4,R1,R2
    vt[6]  = '{enc_r(3'b101, 3'd5, 3'd1, 3'd2),    3'd5, 16'hFFE4, 1'b0, 1'b0}; // MUL R5,R1,R2
    vt[7]  = '{enc_i(3'b000, 3'd7, 3'd0, 7'd16),   3'd7, 16'h0010, 1'b0, 1'b0}; // LOAD R7,#16
    vt[8]  = '{enc_r(3'b101, 3'd7, 3'd7, 3'd7),    3'd7, 16'h0100, 1'b0, 1'b0}; // MUL R7,R7,R7
    vt[9]  = '{enc_i(3'b000, 3'd6, 3'd0, 7'h40),   3'd6, 16'hFFC0, 1'b0, 1'b0}; // LOAD R6,#-64
    vt[10] = '{enc_r(3'b101, 3'd6, 3'd7, 3'd6),    3'd6, 16'hC000, 1'b0, 1'b0}; // MUL R6,R7,R6
    vt[11] = '{enc_r(3'b001, 3'd6, 3'd6, 3'd6),    3'd6, 16'h8000, 1'b0, 1'b0}; // ADD R6,R6,R6
    vt[12] = '{enc_i(3'b100, 3'd1, 3'd6, 7'd1),    3'd1, 16'h7FFF, 1'b0, 1'b1}; // SUBI R1,R6,#1
    vt[13] = '{enc_i(3'b010, 3'd1, 3'd1, 7'd1),    3'd1, 16'h8000, 1'b0, 1'b1}; // ADDI R1,R1,#1
    vt[14] = '{enc_r(3'b101, 3'd5, 3'd7, 3'd7),    3'd5, 16'h0000, 1'b0, 1'b1}; // MUL 0x100*0x100
    vt[15] = '{enc_r(3'b111, 3'd1, 3'd2, 3'd3),    3'd1, 16'h8000, 1'b1, 1'b0}; // illegal 111 rd=R1
    vt[16] = '{enc_r(3'b110, 3'd4, 3'd1, 3'd1),    3'd4, 16'h000B, 1'b1, 1'b0}; // illegal 110 rd=R4
    vt[17] = '{enc_r(3'b001, 3'd1, 3'd1, 3'd1),    3'd1, 16'h0000, 1'b0, 1'b1}; // ADD R1,R1,R1
    for (int i = 0; i < 8; i++) mreg[i] = '0;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    step(); step();
    // Reset state
    chk("rst ready", {31'd0, instr_ready}, 32'd1);
    chk("rst flags", {29'd0, done, illegal, ovf}, 32'd0);
    chk("rst alu", {13'd0, alu_opcode, alu_a}, 32'd0);
    chk("rst alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst done_out", {13'd0, done_rd, done_data}, 32'd0);
    dbg_addr = 3'd5;
    #1;
    chk("rst reg5", {16'd0, dbg_data}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 18; i++) run_vec(i, vt[i]);

    // Valid held high for 10 cycles: one accept every 4 cycles
    done_mask  = '0;
    ready_mask = '0;
    chk("hold ready0", {31'd0, instr_ready}, 32'd1);
    instr       = enc_i(3'b000, 3'd3, 3'd0, 7'd9);
    instr_valid = 1'b1;
    for (int i = 1; i < 15; i++) begin
      step();
      if (i == 10) instr_valid = 1'b0;
      done_mask[i]  = done;
      ready_mask[i] = instr_ready;
    end
    chk("hold done_mask", {17'd0, done_mask}, 32'h0888);
    chk("hold ready_mask", {17'd0, ready_mask}, 32'h7110);
    dbg_addr = 3'd3;
    #1;
    chk("hold R3", {16'd0, dbg_data}, 32'h0009);

    // Reset asserted while an ADD is in EXEC
    issue(enc_r(3'b001, 3'd3, 3'd2, 3'd4));
    step();
    chk("rsthit in_exec", {31'd0, instr_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rsthit ready", {31'd0, instr_ready}, 32'd1);
    chk("rsthit done", {31'd0, done}, 32'd0);
    step();
    chk("rsthit done2", {31'd0, done}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) begin
      dbg_addr = r[2:0];
      #1;
      chk($sformatf("rsthit R%0d", r), {16'd0, dbg_data}, 32'd0);
    end
    done_mask = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      done_mask[i] = done;
    end
    chk("rsthit no_done", {17'd0, done_mask}, 32'd0);
    chk("rsthit ready_after", {31'd0, instr_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
